// File: rtl/bus_pkg.sv
// Shared CPU memory-bus definitions: widths, direction encoding, responder states.
package bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic W_RD_WRITE = 1'b1;
  localparam logic W_RD_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } resp_state_e;

  // True when the upper address bits select the window starting at base.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input int unsigned       bits);
    return (addr >> bits) == (base >> bits);
  endfunction

endpackage

// File: rtl/bus_mem_responder_ram.sv
// Local byte RAM behind the responder: synchronous write and read, no reset.
module resp_ram
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk_1,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_1) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side bus responder: window decode, programmable wait states, one byte
// served per request (read onto the shared bus or write into local RAM).
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned       ADDR_BITS   = 8,
  parameter int unsigned       WAIT_STATES = 1
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              en,
  input  logic              w_rd,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              ready,
  output logic              sel
);

  resp_state_e state, next_state;

  logic [ADDR_BITS-1:0] off;
  logic [ADDR_BITS-1:0] off_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 dir_q;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    rd_q;

  logic same_req_c;
  logic accept_c;
  logic ram_we_c;
  logic ram_re_c;
  logic ready_d_c;
  logic drive_c;

  assign sel = en && in_window(address, BASE_ADDR, ADDR_BITS);
  assign off = address[ADDR_BITS-1:0];

  // The request seen at accept is still being presented unchanged.
  assign same_req_c = sel && (address == addr_q) && (w_rd == dir_q);

  // State register
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sel) next_state = (WAIT_STATES == 0) ? DATA : WAIT;
      end
      WAIT: begin
        if (!same_req_c)            next_state = IDLE;
        else if (cnt == CNT_W'(1))  next_state = DATA;
      end
      DATA: next_state = DONE;
      DONE: begin
        if (!same_req_c) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept_c  = 1'b0;
    ram_we_c  = 1'b0;
    ram_re_c  = 1'b0;
    ready_d_c = 1'b0;
    accept_c  = (state == IDLE) && sel;
    ram_re_c  = (next_state == DATA) && (state != DATA);
    ram_we_c  = (state == DATA) && (dir_q == W_RD_WRITE);
    ready_d_c = (next_state == DATA);
  end

  // Request latch, wait counter and the registered ready pulse
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      off_q  <= '0;
      addr_q <= '0;
      dir_q  <= W_RD_READ;
      cnt    <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= ready_d_c;
      if (accept_c) begin
        off_q  <= off;
        addr_q <= address;
        dir_q  <= w_rd;
        cnt    <= CNT_W'(WAIT_STATES);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  resp_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk_1 (clk_1),
    .we    (ram_we_c),
    .waddr (off_q),
    .wdata (data),
    .re    (ram_re_c),
    .raddr (off),
    .rdata (rd_q)
  );

  // Bus is driven only from registered state; reset releases it at once.
  assign drive_c = (state == DATA) && (dir_q == W_RD_READ) && !rst;
  assign data    = drive_c ? rd_q : {DATA_W{1'bz}};

endmodule
